// File: rtl/mac_row_drain_pkg.sv
// Shared widths, FSM states and lane-word types for the MAC row read-out path.
package mac_row_drain_pkg;

    localparam int unsigned N_LANES     = 8;
    localparam int unsigned ACC_W       = 32;
    localparam int unsigned K_BEATS_DEF = 16;
    localparam int unsigned SEQ_W       = 8;
    localparam int unsigned IDX_W       = $clog2(N_LANES);

    typedef logic [ACC_W-1:0]         acc_word_t;
    typedef logic [N_LANES*ACC_W-1:0] acc_row_t;
    typedef logic [SEQ_W-1:0]         seq_t;

    typedef enum logic [1:0] {
        ST_ACC,
        ST_HOLD,
        ST_CAP
    } drain_state_e;

endpackage

// File: rtl/mac_row_drain_if.sv
// Feed-side and result-stream signals between the MAC row, its drain block and writeback.
interface mac_row_drain_if;
    import mac_row_drain_pkg::*;

    logic      beat_i;
    logic      flush_i;
    logic      feed_ready_o;
    acc_row_t  acc_i;
    logic      acc_clr_o;
    logic      out_valid_o;
    logic      out_ready_i;
    acc_word_t out_data_o;
    logic      out_last_o;
    seq_t      out_seq_o;

    modport master (
        output beat_i, flush_i, acc_i, out_ready_i,
        input  feed_ready_o, acc_clr_o, out_valid_o, out_data_o, out_last_o, out_seq_o
    );

    modport slave (
        input  beat_i, flush_i, acc_i, out_ready_i,
        output feed_ready_o, acc_clr_o, out_valid_o, out_data_o, out_last_o, out_seq_o
    );

endinterface

// File: rtl/mac_row_drain_shadow.sv
// Shadow bank of one captured tile, serialised lane by lane over valid/ready.
module mac_row_drain_shadow
    import mac_row_drain_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      load,
    input  acc_row_t  acc,
    input  seq_t      seq_in,
    input  logic      out_ready,
    output logic      empty_c,
    output logic      last_hs_c,
    output logic      out_valid,
    output acc_word_t out_data,
    output logic      out_last,
    output seq_t      out_seq
);

    acc_word_t        bank [N_LANES];
    logic             full;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] idx_inc_c;
    logic             hs_c;

    assign hs_c      = full && out_ready;
    assign last_hs_c = hs_c && (idx == IDX_W'(N_LANES - 1));
    assign empty_c   = !full;
    assign idx_inc_c = idx + IDX_W'(1);
    assign out_valid = full;

    // Output word and last flag are preloaded so they come straight from flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(N_LANES); i++) bank[i] <= '0;
            full     <= 1'b0;
            idx      <= '0;
            out_data <= '0;
            out_last <= 1'b0;
            out_seq  <= '0;
        end else if (load) begin
            for (int i = 0; i < int'(N_LANES); i++) bank[i] <= acc[i*ACC_W +: ACC_W];
            full     <= 1'b1;
            idx      <= '0;
            out_data <= acc[ACC_W-1:0];
            out_last <= (N_LANES == 1);
            out_seq  <= seq_in;
        end else if (hs_c) begin
            if (last_hs_c) begin
                full     <= 1'b0;
                idx      <= '0;
                out_last <= 1'b0;
            end else begin
                idx      <= idx_inc_c;
                out_data <= bank[idx_inc_c];
                out_last <= (idx_inc_c == IDX_W'(N_LANES - 1));
            end
        end
    end

endmodule

// File: rtl/mac_row_drain.sv
// Counts operand beats into a MAC row, snapshots and clears the row per tile, and streams results.
module mac_row_drain
    import mac_row_drain_pkg::*;
#(
    parameter int unsigned K_BEATS = K_BEATS_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    mac_row_drain_if.slave  bus
);

    localparam int unsigned CNT_W = $clog2(K_BEATS + 1);

    drain_state_e     state, state_nxt;
    logic [CNT_W-1:0] beat_cnt, beat_cnt_nxt;
    seq_t             seq;
    logic             feed_ready;
    logic             acc_clr;
    logic             load_c;
    logic             empty_c;
    logic             last_hs_c;
    logic             tile_done_c;

    // Beats are only counted in ACC; anything presented in HOLD/CAP is dropped.
    always_comb begin
        state_nxt    = state;
        beat_cnt_nxt = beat_cnt;
        load_c       = 1'b0;
        tile_done_c  = 1'b0;
        case (state)
            ST_ACC: begin
                if (bus.beat_i) beat_cnt_nxt = beat_cnt + CNT_W'(1);
                tile_done_c = (bus.beat_i && (beat_cnt_nxt == CNT_W'(K_BEATS)))
                           || (bus.flush_i && ((beat_cnt != '0) || bus.beat_i));
                if (tile_done_c) state_nxt = (empty_c || last_hs_c) ? ST_CAP : ST_HOLD;
            end
            ST_HOLD: begin
                if (empty_c || last_hs_c) state_nxt = ST_CAP;
            end
            ST_CAP: begin
                load_c       = 1'b1;
                beat_cnt_nxt = '0;
                state_nxt    = ST_ACC;
            end
            default: state_nxt = ST_ACC;
        endcase
    end

    // acc_clr resets high so the row is held clear for the whole reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_ACC;
            beat_cnt   <= '0;
            seq        <= '0;
            feed_ready <= 1'b1;
            acc_clr    <= 1'b1;
        end else begin
            state      <= state_nxt;
            beat_cnt   <= beat_cnt_nxt;
            if (load_c) seq <= seq + SEQ_W'(1);
            feed_ready <= (state_nxt == ST_ACC);
            acc_clr    <= (state_nxt == ST_CAP);
        end
    end

    assign bus.feed_ready_o = feed_ready;
    assign bus.acc_clr_o    = acc_clr;

    mac_row_drain_shadow u_shadow (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load_c),
        .acc       (bus.acc_i),
        .seq_in    (seq),
        .out_ready (bus.out_ready_i),
        .empty_c   (empty_c),
        .last_hs_c (last_hs_c),
        .out_valid (bus.out_valid_o),
        .out_data  (bus.out_data_o),
        .out_last  (bus.out_last_o),
        .out_seq   (bus.out_seq_o)
    );

endmodule

// File: tb/tb_mac_row_drain.sv
// Randomised bench for mac_row_drain with a tile-level reference model and stream scoreboard.
module tb_mac_row_drain;
    import mac_row_drain_pkg::*;

    localparam int NL = int'(N_LANES);
    localparam int K  = int'(K_BEATS_DEF);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mac_row_drain_if bus();

    mac_row_drain #(.K_BEATS(K_BEATS_DEF)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural MAC row: adds inc[] on each accepted beat, synchronous clear.
    acc_word_t row [NL];
    acc_word_t inc [NL];
    always @(posedge clk) begin
        for (int l = 0; l < NL; l++) begin
            if (bus.acc_clr_o) row[l] <= '0;
            else if (bus.beat_i && bus.feed_ready_o) row[l] <= row[l] + inc[l];
        end
    end
    always_comb begin
        bus.acc_i = '0;
        for (int l = 0; l < NL; l++) bus.acc_i[l*ACC_W +: ACC_W] = row[l];
    end

    // Tile-level expectation: running lane sums and a queue of expected output words.
    acc_word_t msum [NL];
    int        mcnt;
    int        tile_idx;
    int        tiles_total = 0;
    acc_word_t exp_d [$];
    bit        exp_l [$];
    int        exp_s [$];

    task automatic model_reset();
        mcnt = 0;
        tile_idx = 0;
        for (int l = 0; l < NL; l++) msum[l] = '0;
        exp_d.delete();
        exp_l.delete();
        exp_s.delete();
    endtask

    task automatic set_inc_rand();
        for (int l = 0; l < NL; l++) inc[l] = $urandom;
    endtask

    task automatic set_inc_zero();
        for (int l = 0; l < NL; l++) inc[l] = '0;
    endtask

    // Present one cycle of stimulus, update the model, advance to just after the edge.
    task automatic drive(input bit b, input bit f, input bit r);
        bit legal;
        bus.beat_i      = b;
        bus.flush_i     = f;
        bus.out_ready_i = r;
        legal = b && bus.feed_ready_o;
        if (legal) begin
            for (int l = 0; l < NL; l++) msum[l] = msum[l] + inc[l];
            mcnt++;
        end
        if (bus.feed_ready_o && ((legal && mcnt == K) || (f && mcnt > 0))) begin
            for (int l = 0; l < NL; l++) begin
                exp_d.push_back(msum[l]);
                exp_l.push_back(l == NL - 1);
                exp_s.push_back(tile_idx % 256);
                msum[l] = '0;
            end
            mcnt = 0;
            tile_idx++;
            tiles_total++;
        end
        @(posedge clk);
        #1;
    endtask

    // Stream monitor: ordering, last flag, sequence, stall stability, clear pulses.
    bit        stalled = 1'b0;
    acc_word_t held_d;
    seq_t      held_s;
    int        clr_cnt = 0;
    int        last_seq_seen = -1;
    bit        wrap_seen = 1'b0;
    acc_word_t ed;
    bit        el;
    int        es;

    always @(negedge clk) begin
        if (!rst_n) begin
            stalled = 1'b0;
            last_seq_seen = -1;
        end else begin
            if (bus.acc_clr_o) clr_cnt++;
            if (stalled) begin
                check("stall_valid", 64'(bus.out_valid_o), 64'(1));
                check("stall_data", 64'(bus.out_data_o), 64'(held_d));
                check("stall_seq", 64'(bus.out_seq_o), 64'(held_s));
            end
            if (bus.out_valid_o && bus.out_ready_i) begin
                check("exp_avail", 64'(exp_d.size() > 0), 64'(1));
                if (exp_d.size() > 0) begin
                    ed = exp_d.pop_front();
                    el = exp_l.pop_front();
                    es = exp_s.pop_front();
                    check("word", 64'(bus.out_data_o), 64'(ed));
                    check("last", 64'(bus.out_last_o), 64'(el));
                    check("seq", 64'(bus.out_seq_o), 64'(es));
                    if (bus.out_last_o) begin
                        if (last_seq_seen == 255 && bus.out_seq_o == '0) wrap_seen = 1'b1;
                        last_seq_seen = int'(bus.out_seq_o);
                    end
                end
            end
            stalled = bus.out_valid_o && !bus.out_ready_i;
            held_d  = bus.out_data_o;
            held_s  = bus.out_seq_o;
        end
    end

    int n;
    int c0;

    initial begin
        bus.beat_i      = 1'b0;
        bus.flush_i     = 1'b0;
        bus.out_ready_i = 1'b0;
        set_inc_zero();
        model_reset();

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_feed_ready", 64'(bus.feed_ready_o), 64'(1));
        check("rst_acc_clr", 64'(bus.acc_clr_o), 64'(1));
        check("rst_valid", 64'(bus.out_valid_o), 64'(0));
        check("rst_data", 64'(bus.out_data_o), 64'(0));
        check("rst_last", 64'(bus.out_last_o), 64'(0));
        check("rst_seq", 64'(bus.out_seq_o), 64'(0));
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        drive(0, 0, 1);
        check("rel_acc_clr", 64'(bus.acc_clr_o), 64'(0));
        check("rel_feed_ready", 64'(bus.feed_ready_o), 64'(1));

        // Full tile with lane sums 100*(lane+1)
        for (int i = 0; i < K; i++) begin
            if (i == 0) for (int l = 0; l < NL; l++) inc[l] = acc_word_t'(100 * (l + 1));
            else set_inc_zero();
            drive(1, 0, 1);
        end
        bus.beat_i = 1'b0;
        check("t2_cap_clr", 64'(bus.acc_clr_o), 64'(1));
        check("t2_cap_ready", 64'(bus.feed_ready_o), 64'(0));
        check("t2_cap_valid", 64'(bus.out_valid_o), 64'(0));
        drive(0, 0, 1);
        check("t2_clr_done", 64'(bus.acc_clr_o), 64'(0));
        for (int i = 0; i < NL; i++) begin
            check("t2_valid", 64'(bus.out_valid_o), 64'(1));
            check("t2_word", 64'(bus.out_data_o), 64'(100 * (i + 1)));
            check("t2_last", 64'(bus.out_last_o), 64'(i == NL - 1));
            check("t2_seq", 64'(bus.out_seq_o), 64'(0));
            drive(0, 0, 1);
        end
        check("t2_clr_once", 64'(clr_cnt), 64'(1));
        check("t2_empty", 64'(bus.out_valid_o), 64'(0));

        // Backpressure: two tiles complete, second parks in HOLD
        for (int i = 0; i < 40; i++) begin
            set_inc_rand();
            drive(1, 0, 0);
        end
        check("t3_hold_ready", 64'(bus.feed_ready_o), 64'(0));
        check("t3_hold_valid", 64'(bus.out_valid_o), 64'(1));
        n = 0;
        while (!bus.feed_ready_o && n < 30) begin
            drive(0, 0, 1);
            n++;
        end
        check("t3_resume", 64'(bus.feed_ready_o), 64'(1));
        repeat (12) drive(0, 0, 1);
        check("t3_drained", 64'(exp_d.size()), 64'(0));

        // Beat presented during CAP must not count toward the next tile
        for (int i = 0; i < K; i++) begin
            set_inc_rand();
            drive(1, 0, 1);
        end
        drive(1, 0, 1);
        for (int i = 0; i < K - 1; i++) begin
            set_inc_rand();
            drive(1, 0, 1);
        end
        check("t6_no_cap_ready", 64'(bus.feed_ready_o), 64'(1));
        check("t6_no_cap_clr", 64'(bus.acc_clr_o), 64'(0));
        set_inc_rand();
        drive(1, 0, 1);
        check("t6_cap_clr", 64'(bus.acc_clr_o), 64'(1));
        repeat (12) drive(0, 0, 1);

        // Flush: partial tile, flush with no beats, flush with a single beat
        for (int i = 0; i < 5; i++) begin
            set_inc_rand();
            drive(1, 0, 1);
        end
        drive(0, 1, 1);
        check("t4_flush_clr", 64'(bus.acc_clr_o), 64'(1));
        repeat (12) drive(0, 0, 1);
        c0 = clr_cnt;
        drive(0, 1, 1);
        check("t4_idle_flush_clr", 64'(bus.acc_clr_o), 64'(0));
        check("t4_idle_flush_ready", 64'(bus.feed_ready_o), 64'(1));
        drive(0, 0, 1);
        check("t4_idle_flush_valid", 64'(bus.out_valid_o), 64'(0));
        check("t4_idle_flush_pulses", 64'(clr_cnt), 64'(c0));
        set_inc_rand();
        drive(1, 1, 1);
        check("t4_beat_flush_clr", 64'(bus.acc_clr_o), 64'(1));
        repeat (12) drive(0, 0, 1);

        // Reset in the middle of a tile with a full shadow
        for (int i = 0; i < K + 7; i++) begin
            set_inc_rand();
            drive(1, 0, 0);
        end
        check("t1_pre_valid", 64'(bus.out_valid_o), 64'(1));
        rst_n = 1'b0;
        bus.beat_i = 1'b0;
        #1;
        check("t1_mid_acc_clr", 64'(bus.acc_clr_o), 64'(1));
        check("t1_mid_feed_ready", 64'(bus.feed_ready_o), 64'(1));
        check("t1_mid_valid", 64'(bus.out_valid_o), 64'(0));
        check("t1_mid_data", 64'(bus.out_data_o), 64'(0));
        check("t1_mid_seq", 64'(bus.out_seq_o), 64'(0));
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        drive(0, 0, 1);
        check("t1_rel_acc_clr", 64'(bus.acc_clr_o), 64'(0));
        check("t1_rel_feed_ready", 64'(bus.feed_ready_o), 64'(1));

        // Random traffic over 300 tiles with random stalls, flushes and illegal beats
        n = 0;
        while (tile_idx < 300 && n < 40000) begin
            set_inc_rand();
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0, $urandom_range(0, 1) == 1);
            n++;
        end
        check("t5_budget", 64'(n < 40000), 64'(1));
        n = 0;
        while (exp_d.size() > 0 && n < 500) begin
            drive(0, 0, 1);
            n++;
        end
        check("t5_drained", 64'(exp_d.size()), 64'(0));
        repeat (4) drive(0, 0, 1);
        check("t5_final_valid", 64'(bus.out_valid_o), 64'(0));
        check("clr_pulses", 64'(clr_cnt), 64'(tiles_total));
        check("seq_wrap", 64'(wrap_seen), 64'(1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
